mem_stage: RTL and testbench

Memory-access stage of the 16-bit pipelined core, directly downstream of the execute stage and upstream of writeback. It registers execute results, performs LOAD/STORE transactions against data memory over a req/ack handshake, stalls the front of the pipeline while a transaction is outstanding, and presents the writeback data, index and enable to the register file.

---
 rtl/mem_stage.sv | 134 +++++++++++++
 tb/tb_mem_stage.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access stage: registers execute results, runs LOAD/STORE over req/ack, stalls upstream.
// Optional MEM_TIMEOUT_EN adds an ACCESS watchdog with a sticky mem_error flag.
//
// state    | meaning
// S_IDLE   | sampling execute outputs every edge
// S_ACCESS | memory transaction outstanding, upstream stalled
module mem_stage #(
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        control_in,
  input  logic [DATA_W-1:0] result_in,
  input  logic [DATA_W-1:0] store_data_in,
  input  logic [4:0]        dest_index_in,
  input  logic              dest_reg_write_en_in,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall,
  output logic [DATA_W-1:0] wb_data,
  output logic [4:0]        wb_index,
  output logic              wb_en,
  output logic [3:0]        control_out,
  output logic              mem_error
);

  localparam logic [3:0] OP_NOP   = 4'b0000;
  localparam logic [3:0] OP_LOAD  = 4'b1100;
  localparam logic [3:0] OP_STORE = 4'b1110;

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  state_t     state, state_next;
  logic [4:0] lat_idx;
  logic       is_load, is_store, is_mem;
  logic       timeout_hit;

  assign is_load  = (control_in == OP_LOAD);
  assign is_store = (control_in == OP_STORE);
  assign is_mem   = is_load || is_store;
  assign stall    = (state == S_ACCESS);

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] to_cnt;

  // Abort on the edge that would bring the count to TIMEOUT.
  assign timeout_hit = (state == S_ACCESS) && !mem_ack && (to_cnt == TO_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt <= 8'd0;
    end else if (state == S_IDLE) begin
      if (is_mem) to_cnt <= 8'd0;
    end else if (!mem_ack) begin
      to_cnt <= to_cnt + 8'd1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign mem_error   = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (is_mem) state_next = S_ACCESS;
      S_ACCESS: if (mem_ack || timeout_hit) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      lat_idx     <= 5'd0;
      wb_data     <= '0;
      wb_index    <= 5'd0;
      wb_en       <= 1'b0;
      control_out <= OP_NOP;
`ifdef MEM_TIMEOUT_EN
      mem_error   <= 1'b0;
`endif
    end else if (state == S_IDLE) begin
      if (is_mem) begin
        mem_req     <= 1'b1;
        mem_we      <= is_store;
        mem_addr    <= result_in;
        mem_wdata   <= store_data_in;
        lat_idx     <= dest_index_in;
        wb_en       <= 1'b0;
        control_out <= OP_NOP;
      end else begin
        wb_data     <= result_in;
        wb_index    <= dest_index_in;
        wb_en       <= dest_reg_write_en_in;
        control_out <= control_in;
      end
    end else if (mem_ack) begin
      mem_req <= 1'b0;
      // mem_we doubles as the latched LOAD/STORE distinction.
      if (!mem_we) begin
        wb_data     <= mem_rdata;
        wb_index    <= lat_idx;
        wb_en       <= 1'b1;
        control_out <= OP_LOAD;
      end else begin
        wb_en       <= 1'b0;
        control_out <= OP_STORE;
      end
    end else if (timeout_hit) begin
      mem_req     <= 1'b0;
      wb_en       <= 1'b0;
      control_out <= OP_NOP;
`ifdef MEM_TIMEOUT_EN
      mem_error   <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage; timeout scenario runs when MEM_TIMEOUT_EN is defined.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  control_in;
  logic [15:0] result_in, store_data_in, mem_rdata;
  logic [4:0]  dest_index_in;
  logic        dest_reg_write_en_in, mem_ack;
  logic        mem_req, mem_we, stall, wb_en, mem_error;
  logic [15:0] mem_addr, mem_wdata, wb_data;
  logic [4:0]  wb_index;
  logic [3:0]  control_out;

  int n_total = 0;
  int n_pass  = 0;

  mem_stage #(.DATA_W(16), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .control_in(control_in), .result_in(result_in),
    .store_data_in(store_data_in), .dest_index_in(dest_index_in),
    .dest_reg_write_en_in(dest_reg_write_en_in), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall(stall), .wb_data(wb_data), .wb_index(wb_index), .wb_en(wb_en),
    .control_out(control_out), .mem_error(mem_error)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed running, required finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h, required %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [15:0] res, input logic [15:0] sd,
                       input logic [4:0] idx, input logic we);
    control_in = op; result_in = res; store_data_in = sd;
    dest_index_in = idx; dest_reg_write_en_in = we;
  endtask

  initial begin
    reset = 1'b1; mem_ack = 1'b0; mem_rdata = 16'h0;
    drive(4'b0000, 16'h0, 16'h0, 5'd0, 1'b0);
    tick(); tick();
    chk("rst_req", 16'(mem_req), 16'h0);
    chk("rst_stall", 16'(stall), 16'h0);
    chk("rst_wb_en", 16'(wb_en), 16'h0);
    chk("rst_addr", mem_addr, 16'h0);
    chk("rst_wb_data", wb_data, 16'h0);
    chk("rst_ctrl", 16'(control_out), 16'h0);
    chk("rst_err", 16'(mem_error), 16'h0);
    #3 reset = 1'b0;

    // ADD
    drive(4'b0010, 16'h0042, 16'h0, 5'd5, 1'b1);
    tick();
    chk("add_data", wb_data, 16'h0042);
    chk("add_idx", 16'(wb_index), 16'd5);
    chk("add_en", 16'(wb_en), 16'h1);
    chk("add_ctrl", 16'(control_out), 16'h2);
    chk("add_stall", 16'(stall), 16'h0);

    // LOAD, ack in 3rd ACCESS cycle
    drive(4'b1100, 16'h0010, 16'h5555, 5'd7, 1'b1);
    tick();
    chk("ld_req1", 16'(mem_req), 16'h1);
    chk("ld_stall1", 16'(stall), 16'h1);
    chk("ld_we", 16'(mem_we), 16'h0);
    chk("ld_addr", mem_addr, 16'h0010);
    chk("ld_wben_acc", 16'(wb_en), 16'h0);
    chk("ld_ctrl_acc", 16'(control_out), 16'h0);
    drive(4'b0000, 16'h0, 16'h0, 5'd0, 1'b0);
    tick();
    chk("ld_stall2", 16'(stall), 16'h1);
    tick();
    chk("ld_stall3", 16'(stall), 16'h1);
    chk("ld_req3", 16'(mem_req), 16'h1);
    mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    tick();
    mem_ack = 1'b0; mem_rdata = 16'h0;
    chk("ld_req_done", 16'(mem_req), 16'h0);
    chk("ld_stall_done", 16'(stall), 16'h0);
    chk("ld_data", wb_data, 16'hBEEF);
    chk("ld_idx", 16'(wb_index), 16'd7);
    chk("ld_en", 16'(wb_en), 16'h1);
    chk("ld_ctrl", 16'(control_out), 16'hC);

    // STORE, zero-wait
    drive(4'b1110, 16'h0020, 16'h1234, 5'd3, 1'b0);
    tick();
    chk("st_we", 16'(mem_we), 16'h1);
    chk("st_wdata", mem_wdata, 16'h1234);
    chk("st_addr", mem_addr, 16'h0020);
    chk("st_stall", 16'(stall), 16'h1);
    mem_ack = 1'b1;
    drive(4'b0000, 16'h0, 16'h0, 5'd0, 1'b0);
    tick();
    mem_ack = 1'b0;
    chk("st_stall_done", 16'(stall), 16'h0);
    chk("st_req_done", 16'(mem_req), 16'h0);
    chk("st_en", 16'(wb_en), 16'h0);
    chk("st_ctrl", 16'(control_out), 16'hE);

    // LOAD then STORE held under stall
    drive(4'b1100, 16'h0030, 16'h0, 5'd9, 1'b1);
    tick();
    drive(4'b1110, 16'h0040, 16'hABCD, 5'd1, 1'b0);
    mem_ack = 1'b1; mem_rdata = 16'h1111;
    tick();
    mem_ack = 1'b0;
    chk("b2b_ld_data", wb_data, 16'h1111);
    chk("b2b_ld_ctrl", 16'(control_out), 16'hC);
    chk("b2b_gap_stall", 16'(stall), 16'h0);
    tick();
    chk("b2b_st_req", 16'(mem_req), 16'h1);
    chk("b2b_st_addr", mem_addr, 16'h0040);
    chk("b2b_st_wdata", mem_wdata, 16'hABCD);
    chk("b2b_st_we", 16'(mem_we), 16'h1);
    drive(4'b0000, 16'h0, 16'h0, 5'd0, 1'b0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("b2b_st_ctrl", 16'(control_out), 16'hE);
    chk("b2b_st_en", 16'(wb_en), 16'h0);

    // Reset in 2nd ACCESS cycle
    drive(4'b1100, 16'h0050, 16'h0, 5'd4, 1'b1);
    tick();
    drive(4'b0000, 16'h0, 16'h0, 5'd0, 1'b0);
    tick();
    chk("mid_req_pre", 16'(mem_req), 16'h1);
    #2 reset = 1'b1;
    #1;
    chk("mid_req", 16'(mem_req), 16'h0);
    chk("mid_stall", 16'(stall), 16'h0);
    chk("mid_wb_en", 16'(wb_en), 16'h0);
    #2 reset = 1'b0;
    mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    tick();
    mem_ack = 1'b0;
    chk("stray_wb_en", 16'(wb_en), 16'h0);
    chk("stray_wb_data", wb_data, 16'h0);
    chk("stray_stall", 16'(stall), 16'h0);

    // ADD after recovery
    drive(4'b0010, 16'h0077, 16'h0, 5'd2, 1'b1);
    tick();
    chk("add2_data", wb_data, 16'h0077);
    chk("add2_en", 16'(wb_en), 16'h1);

`ifdef MEM_TIMEOUT_EN
    drive(4'b1100, 16'h0060, 16'h0, 5'd6, 1'b1);
    tick();
    drive(4'b0000, 16'h0, 16'h0, 5'd0, 1'b0);
    chk("to_req1", 16'(mem_req), 16'h1);
    tick(); tick(); tick();
    chk("to_req4", 16'(mem_req), 16'h1);
    chk("to_err_pre", 16'(mem_error), 16'h0);
    tick();
    chk("to_req_drop", 16'(mem_req), 16'h0);
    chk("to_stall", 16'(stall), 16'h0);
    chk("to_err", 16'(mem_error), 16'h1);
    chk("to_wb_en", 16'(wb_en), 16'h0);
    chk("to_ctrl", 16'(control_out), 16'h0);
    drive(4'b0010, 16'h0099, 16'h0, 5'd8, 1'b1);
    tick();
    chk("to_add_data", wb_data, 16'h0099);
    chk("to_add_en", 16'(wb_en), 16'h1);
    chk("to_err_sticky", 16'(mem_error), 16'h1);
`else
    chk("err_tied", 16'(mem_error), 16'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
